// File: rtl/ktlink_pkg.sv
// Shared definitions for the KT-Link status stage: filter state encoding,
// synchronizer reset levels and default parameter values.
package ktlink_pkg;

    typedef enum logic [1:0] {
        ST_HIGH      = 2'd0,
        ST_FALL_QUAL = 2'd1,
        ST_LOW       = 2'd2,
        ST_RISE_QUAL = 2'd3
    } filt_state_t;

    localparam logic NSRST_SYNC_RESET = 1'b1;
    localparam logic TCK_SYNC_RESET   = 1'b0;
    // Host LED request is active-low, so its synchronizer idles "off".
    localparam logic LED_SYNC_RESET   = 1'b1;

    localparam int DEF_NSRST_FILT_CYCLES = 16;
    localparam int DEF_LED_HOLD_W        = 20;
    localparam int DEF_BLINK_BIT         = 18;

endpackage

// File: rtl/ktlink_deglitch.sv
// Two-flop synchronizer plus level-qualification filter for a slow target
// sense line; emits the filtered level and a pulse on each accepted fall.
module ktlink_deglitch
    import ktlink_pkg::*;
#(
    parameter int   FILT_CYCLES = DEF_NSRST_FILT_CYCLES,
    parameter logic RESET_LEVEL = NSRST_SYNC_RESET
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall_pulse
);

    localparam logic [7:0] LAST_COUNT = 8'(FILT_CYCLES - 1);
    localparam filt_state_t IDLE_STATE = RESET_LEVEL ? ST_HIGH : ST_LOW;

    logic [1:0]  sync;
    logic        s_in;
    filt_state_t state;
    filt_state_t state_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic        pulse_next;
    logic        level_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {2{RESET_LEVEL}};
        end else begin
            sync <= {sync[0], din};
        end
    end

    assign s_in = sync[1];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state)
            ST_HIGH: begin
                if (!s_in) begin
                    state_next = ST_FALL_QUAL;
                    cnt_next   = 8'd1;
                end
            end
            ST_FALL_QUAL: begin
                if (s_in) begin
                    state_next = ST_HIGH;
                    cnt_next   = 8'd0;
                end else if (cnt == LAST_COUNT) begin
                    state_next = ST_LOW;
                    cnt_next   = 8'd0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_LOW: begin
                if (s_in) begin
                    state_next = ST_RISE_QUAL;
                    cnt_next   = 8'd1;
                end
            end
            ST_RISE_QUAL: begin
                if (!s_in) begin
                    state_next = ST_LOW;
                    cnt_next   = 8'd0;
                end else if (cnt == LAST_COUNT) begin
                    state_next = ST_HIGH;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE_STATE;
                cnt_next   = 8'd0;
            end
        endcase
        // Qualifying states keep reporting the old level until accepted.
        level_next = (state_next == ST_HIGH) || (state_next == ST_FALL_QUAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE_STATE;
            cnt        <= 8'd0;
            level      <= RESET_LEVEL;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            level      <= level_next;
            fall_pulse <= pulse_next;
        end
    end

endmodule

// File: rtl/ktlink_status.sv
// KT-Link status stage: deglitched nSRST sense for the FT2232 and an
// activity-aware LED that blinks while TCK is toggling.
module ktlink_status
    import ktlink_pkg::*;
#(
    parameter int NSRST_FILT_CYCLES = DEF_NSRST_FILT_CYCLES,
    parameter int LED_HOLD_W        = DEF_LED_HOLD_W,
    parameter int BLINK_BIT         = DEF_BLINK_BIT
) (
    input  logic CLK,
    input  logic RST,
    input  logic nSRST_PIN,
    input  logic TCK_MON,
    input  logic FT_LED_OUT,
    output logic FT_nSRST_IN,
    output logic SRST_PULSE,
    output logic LED
);

    logic [1:0]            tck_sync;
    logic                  tck_prev;
    logic                  tck_edge;
    logic [1:0]            led_sync;
    logic [LED_HOLD_W-1:0] hold;
    logic [LED_HOLD_W-1:0] blink;
    logic                  active;
    logic                  led_next;

    ktlink_deglitch #(
        .FILT_CYCLES (NSRST_FILT_CYCLES),
        .RESET_LEVEL (NSRST_SYNC_RESET)
    ) u_nsrst (
        .clk        (CLK),
        .rst        (RST),
        .din        (nSRST_PIN),
        .level      (FT_nSRST_IN),
        .fall_pulse (SRST_PULSE)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tck_sync <= {2{TCK_SYNC_RESET}};
            tck_prev <= TCK_SYNC_RESET;
            led_sync <= {2{LED_SYNC_RESET}};
        end else begin
            tck_sync <= {tck_sync[0], TCK_MON};
            tck_prev <= tck_sync[1];
            led_sync <= {led_sync[0], FT_LED_OUT};
        end
    end

    assign tck_edge = tck_sync[1] & ~tck_prev;
    assign active   = (hold != '0);

    // An edge always wins over the decrement, so a reload on the final count keeps the LED active.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold  <= '0;
            blink <= '0;
        end else begin
            blink <= blink + LED_HOLD_W'(1);
            if (tck_edge) begin
                hold <= '1;
            end else if (active) begin
                hold <= hold - LED_HOLD_W'(1);
            end
        end
    end

    always_comb begin
        led_next = 1'b0;
        if (active) begin
            led_next = blink[BLINK_BIT];
        end else if (!led_sync[1]) begin
            led_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LED <= 1'b0;
        end else begin
            LED <= led_next;
        end
    end

endmodule
